resp_merge: RTL
===============

# resp_merge

Parametrised N-channel response merger, successor to the two-channel combinational output mux. Collects one-cycle response pulses (2-bit resp plus data word) from NCH producer channels, buffers each in a per-channel FIFO so simultaneous responses are never lost, and drains them one per cycle in round-robin order onto a single registered response port tagged with the source channel. Sits between the calc1 execution units and the port output logic.

## Interface
- NCH, 4: number of input channels (2..8)
- DATA_W, 32: data word width
- DEPTH, 4: per-channel FIFO depth (power of two, >= 2)
- c_clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- in_resp  in  2*NCH  channel k resp at bits [2k:2k+1]; 2'b00 = no response
- in_data  in  DATA_W*NCH  channel k data at bits [k*DATA_W : k*DATA_W+DATA_W-1]
- out_resp  out  2  merged resp, registered; 2'b00 when idle
- out_data  out  DATA_W  merged data, registered; 0 when out_resp = 2'b00
- out_tag  out  max(1,$clog2(NCH))  source channel of current out_resp; 0 when idle
- drop  out  NCH  sticky per-channel overflow flag
- clr_drop  in  1  synchronous clear of all drop bits
- Bit order big-endian ([0:N-1], bit 0 = MSB), as across calc1.

## Operation
- Capture: each edge, every channel with in_resp != 2'b00 pushes {resp,data} into its FIFO. Resp codes passed through unchanged, never interpreted.
- Arbitration: among channels with non-empty FIFO, grant first in round-robin order starting at last_grant+1 (mod NCH); pop its head; register head into out_resp/out_data/out_tag. last_grant updates only on a grant.
- Output is a single-cycle pulse per response; no downstream backpressure; at most one response emitted per cycle.
- Overflow: push to full FIFO with no pop same cycle -> word discarded, drop[k] set. Full FIFO with pop same cycle -> push accepted.
- drop[k] cleared by clr_drop; set wins over clear in same cycle.
- Idle: no FIFO non-empty -> out_resp = 2'b00, out_data = 0, out_tag = 0.
- Reset (any time, incl. mid-drain): FIFOs emptied, pointers 0, last_grant = NCH-1 (so channel 0 has first priority), all outputs 0, drop = 0, counters 0. In-flight responses lost.

## Timing
- Response presented in cycle n is captured at edge n+1 and, if granted immediately, appears on out_* during cycle n+1 → n+2 (after edge n+2): 2-edge latency minimum.
- Worst-case latency for a response at FIFO head: NCH cycles after it reaches the head.
- FIFO write and read pointers wrap modulo DEPTH; occupancy counter 0..DEPTH.
- Sustained throughput: 1 response/cycle total; a channel is guaranteed 1/NCH of the bandwidth under full load.

## Configuration
- RESP_MERGE_CNT_EN defined: adds output port fwd_cnt (16*NCH), one 16-bit per-channel count of responses forwarded; wraps 16'hFFFF -> 0; reset to 0; unaffected by clr_drop.
- Undefined: port and counters absent; all other behaviour identical.

## Structure
- Package resp_merge_pkg: resp code constants (RESP_NONE=2'b00, RESP_OK=2'b01, RESP_OVF=2'b10, RESP_INV=2'b11), entry struct/width localparam {resp,data}, counter width constant.
- Sub-module resp_fifo: single-channel FIFO (push, pop, full, empty, head), instantiated NCH times; round-robin arbiter and output register in top.

## Test plan
- Single response: ch0 resp=01 data=4096 for one cycle -> two edges later out_resp=01, out_data=4096, out_tag=0 for exactly one cycle, then 00.
- Collision: ch0 (01,4096) and ch1 (01,1234) same cycle -> outputs on consecutive cycles, tag 0 then 1; next collision starts at ch2 onward.
- Overflow (DEPTH=4): ch2 pushes 6 consecutive cycles while ch0/ch1 kept busy -> early pops free slots; any push to full FIFO without same-cycle pop sets drop[2]; clr_drop clears it; delivered words in push order.
- Full fairness: all NCH=4 channels push every cycle -> tags cycle 0,1,2,3,0,... with no starvation.
- Reset mid-drain: assert reset with 3 entries queued -> outputs 0 immediately (async), nothing emitted after release, first post-reset grant goes to channel 0.
- RESP_MERGE_CNT_EN: forward 3 responses on ch1 -> fwd_cnt ch1 = 3, others 0; preset to 16'hFFFF via 65535 pushes or force -> wraps to 0.

Source files
------------

// File: rtl/resp_merge_pkg.sv
// Shared constants for the N-channel response merger.
// Resp codes are forwarded untouched; a FIFO entry is {resp, data}.
package resp_merge_pkg;

  localparam int RESP_W = 2;
  localparam int CNT_W  = 16;

  localparam logic [RESP_W-1:0] RESP_NONE = 2'b00;
  localparam logic [RESP_W-1:0] RESP_OK   = 2'b01;
  localparam logic [RESP_W-1:0] RESP_OVF  = 2'b10;
  localparam logic [RESP_W-1:0] RESP_INV  = 2'b11;

  typedef logic [RESP_W-1:0] resp_t;

  function automatic int entry_w(input int data_w);
    return RESP_W + data_w;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Single-channel response FIFO; a push to a full FIFO is accepted only
// when a pop happens in the same cycle.
module resp_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 4
) (
  input  logic         c_clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          push_ok_s, pop_ok_s;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == {CW{1'b0}});
  assign head  = mem_q[rd_q];

  always_comb begin
    mem_d     = mem_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    push_ok_s = push && (!full || pop);
    pop_ok_s  = pop && !empty;
    if (push_ok_s) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + PW'(1);
    end else begin
      wr_d = wr_q;
    end
    if (pop_ok_s) begin
      rd_d = rd_q + PW'(1);
    end else begin
      rd_d = rd_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      wr_q  <= {PW{1'b0}};
      rd_q  <= {PW{1'b0}};
      cnt_q <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {W{1'b0}};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/resp_merge.sv
// N-channel response merger: per-channel FIFOs drained round-robin onto one
// registered, channel-tagged port. RESP_MERGE_CNT_EN adds per-channel fwd_cnt.
module resp_merge
  import resp_merge_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int TAG_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    c_clk,
  input  logic                    reset,
  input  logic [0:2*NCH-1]        in_resp,
  input  logic [0:DATA_W*NCH-1]   in_data,
  output logic [0:1]              out_resp,
  output logic [0:DATA_W-1]       out_data,
  output logic [0:TAG_W-1]        out_tag,
  output logic [0:NCH-1]          drop,
  input  logic                    clr_drop
`ifdef RESP_MERGE_CNT_EN
  ,
  output logic [0:CNT_W*NCH-1]    fwd_cnt
`endif
);

  localparam int EW = entry_w(DATA_W);

  logic [0:NCH-1]     push_s, pop_s, full_s, empty_s, ovf_s;
  logic [EW-1:0]      din_s  [NCH];
  logic [EW-1:0]      head_s [NCH];
  logic               grant_vld_s;
  logic [TAG_W-1:0]   grant_idx_s, rr_cand_s;
  int                 rr_idx_s;
  logic [TAG_W-1:0]   last_grant_q, last_grant_d;
  logic [RESP_W-1:0]  out_resp_q, out_resp_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic [0:NCH-1]     drop_q, drop_d;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign push_s[k] = (in_resp[2*k +: 2] != RESP_NONE);
    assign din_s[k]  = {in_resp[2*k +: 2], in_data[k*DATA_W +: DATA_W]};
    assign pop_s[k]  = grant_vld_s && (grant_idx_s == TAG_W'(k));
    assign ovf_s[k]  = push_s[k] && full_s[k] && !pop_s[k];

    resp_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
      .c_clk (c_clk),
      .reset (reset),
      .push  (push_s[k]),
      .pop   (pop_s[k]),
      .din   (din_s[k]),
      .full  (full_s[k]),
      .empty (empty_s[k]),
      .head  (head_s[k])
    );
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = {TAG_W{1'b0}};
    rr_idx_s    = 0;
    rr_cand_s   = {TAG_W{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      rr_idx_s = int'(last_grant_q) + i + 32'sd1;
      if (rr_idx_s >= NCH) begin
        rr_idx_s = rr_idx_s - NCH;
      end else begin
        rr_idx_s = rr_idx_s;
      end
      rr_cand_s = TAG_W'(rr_idx_s);
      if (!grant_vld_s && !empty_s[rr_cand_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = rr_cand_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  always_comb begin
    out_resp_d   = RESP_NONE;
    out_data_d   = {DATA_W{1'b0}};
    out_tag_d    = {TAG_W{1'b0}};
    last_grant_d = last_grant_q;
    drop_d       = drop_q;
    if (grant_vld_s) begin
      out_resp_d   = head_s[grant_idx_s][EW-1 -: RESP_W];
      out_data_d   = head_s[grant_idx_s][DATA_W-1:0];
      out_tag_d    = grant_idx_s;
      last_grant_d = grant_idx_s;
    end else begin
      last_grant_d = last_grant_q;
    end
    // An overflow in the same cycle as clr_drop keeps the flag set.
    for (int k = 0; k < NCH; k++) begin
      if (ovf_s[k]) begin
        drop_d[k] = 1'b1;
      end else if (clr_drop) begin
        drop_d[k] = 1'b0;
      end else begin
        drop_d[k] = drop_q[k];
      end
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      out_resp_q   <= RESP_NONE;
      out_data_q   <= {DATA_W{1'b0}};
      out_tag_q    <= {TAG_W{1'b0}};
      last_grant_q <= TAG_W'(NCH - 1);
      drop_q       <= {NCH{1'b0}};
    end else begin
      out_resp_q   <= out_resp_d;
      out_data_q   <= out_data_d;
      out_tag_q    <= out_tag_d;
      last_grant_q <= last_grant_d;
      drop_q       <= drop_d;
    end
  end

  assign out_resp = out_resp_q;
  assign out_data = out_data_q;
  assign out_tag  = out_tag_q;
  assign drop     = drop_q;

`ifdef RESP_MERGE_CNT_EN
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < NCH; k++) begin
      if (pop_s[k]) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end else begin
        cnt_d[k] = cnt_q[k];
      end
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) cnt_q[k] <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_cnt
    assign fwd_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
  end
`endif

endmodule
